// File: rtl/up_cnt_mod_pkg.sv
// Shared types and helpers for the modulo-N up-counter.
// The counter's next-state choice is reduced to one operation code so the
// datapath mux is a single case statement. OP_LOAD is only selected when
// the build defines UP_CNT_MOD_LOAD_EN.
package up_cnt_mod_pkg;

    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_INC   = 3'd1,
        OP_WRAP  = 3'd2,
        OP_CLEAR = 3'd3,
        OP_LOAD  = 3'd4
    } cnt_op_e;

    // Priority: clear, then parallel load, then count enable.
    function automatic cnt_op_e sel_op(
        input logic clr,
        input logic ld,
        input logic ce,
        input logic at_term
    );
        cnt_op_e op;
        if (clr) begin
            op = OP_CLEAR;
        end else if (ld) begin
            op = OP_LOAD;
        end else if (ce) begin
            if (at_term) begin
                op = OP_WRAP;
            end else begin
                op = OP_INC;
            end
        end else begin
            op = OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/up_cnt_mod.sv
// Synchronous modulo-MODULO up-counter with clock enable and combinational
// carry-out, intended to be cascaded (CO of one stage drives CE of the next).
// Optional macro UP_CNT_MOD_LOAD_EN adds a synchronous parallel load (LD, D).
module up_cnt_mod
    import up_cnt_mod_pkg::*;
#(
    parameter int MODULO = 10,
    parameter int W      = 4
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic         CE,
`ifdef UP_CNT_MOD_LOAD_EN
    input  logic         LD,
    input  logic [W-1:0] D,
`endif
    output logic [W-1:0] Q,
    output logic         CO
);

    // Modulus must fit the counter width and give at least two states.
    generate
        if ((MODULO < 2) || (longint'(MODULO) > (64'd1 << W))) begin : g_bad_modulo
            $error("up_cnt_mod: MODULO=%0d is illegal for W=%0d", MODULO, W);
        end
    endgenerate

    // Terminal count; the wrap is decoded from it explicitly so that
    // MODULO == 2**W never relies on natural overflow.
    localparam logic [W-1:0] TERM    = W'(MODULO - 1);
    // Modulus extended by one bit so 2**W is representable for the load check.
    localparam logic [W:0]   MOD_EXT = (W+1)'(MODULO);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic         at_term_s;
    logic         ld_s;
    logic [W-1:0] ld_val_s;
    cnt_op_e      op_s;

`ifdef UP_CNT_MOD_LOAD_EN
    assign ld_s = LD;

    // Out-of-range load data is forced to zero so Q never leaves 0..MODULO-1.
    always_comb begin
        ld_val_s = '0;
        if ({1'b0, D} < MOD_EXT) begin
            ld_val_s = D;
        end else begin
            ld_val_s = '0;
        end
    end
`else
    assign ld_s     = 1'b0;
    assign ld_val_s = '0;
`endif

    assign at_term_s = (q_q == TERM);
    assign op_s      = sel_op(CLR, ld_s, CE, at_term_s);

    // Next-state selection for the count register.
    always_comb begin
        q_d = q_q;
        case (op_s)
            OP_CLEAR: q_d = '0;
            OP_LOAD:  q_d = ld_val_s;
            OP_WRAP:  q_d = '0;
            OP_INC:   q_d = q_q + W'(1);
            OP_HOLD:  q_d = q_q;
            default:  q_d = '0;
        endcase
    end

    // Count register; CLR is also honoured here directly as the top priority.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q  = q_q;
    // Carry is combinational so a downstream stage on the same clock
    // increments on exactly the edge where this stage wraps.
    assign CO = CE & at_term_s;

endmodule

// File: tb/tb_up_cnt_mod.sv
// Self-checking bench for up_cnt_mod: vector table, hand-written corner
// sequences, a two-decade cascade, a full-range modulus instance and a
// randomized run against an arithmetic reference model.
module tb_up_cnt_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // MODULO=10 main instance
    logic       clr10 = 1'b1, ce10 = 1'b0, ld10 = 1'b0;
    logic [3:0] d10 = 4'd0;
    logic [3:0] q10;
    logic       co10;

    // MODULO=16 full-range instance
    logic       clr16 = 1'b1, ce16 = 1'b0;
    logic [3:0] q16;
    logic       co16;

    // Two-decade cascade
    logic       cclr = 1'b1, cce0 = 1'b0;
    logic [3:0] cq0, cq1;
    logic       cco0, cco1;

    logic       ld_off = 1'b0;
    logic [3:0] d_off  = 4'd0;

`ifdef UP_CNT_MOD_LOAD_EN
    localparam bit LOAD_EN = 1'b1;
`else
    localparam bit LOAD_EN = 1'b0;
`endif

    up_cnt_mod #(.MODULO(10), .W(4)) u_m10 (
        .CLK(clk), .CLR(clr10), .CE(ce10),
`ifdef UP_CNT_MOD_LOAD_EN
        .LD(ld10), .D(d10),
`endif
        .Q(q10), .CO(co10)
    );

    up_cnt_mod #(.MODULO(16), .W(4)) u_m16 (
        .CLK(clk), .CLR(clr16), .CE(ce16),
`ifdef UP_CNT_MOD_LOAD_EN
        .LD(ld_off), .D(d_off),
`endif
        .Q(q16), .CO(co16)
    );

    up_cnt_mod #(.MODULO(10), .W(4)) u_c0 (
        .CLK(clk), .CLR(cclr), .CE(cce0),
`ifdef UP_CNT_MOD_LOAD_EN
        .LD(ld_off), .D(d_off),
`endif
        .Q(cq0), .CO(cco0)
    );

    up_cnt_mod #(.MODULO(10), .W(4)) u_c1 (
        .CLK(clk), .CLR(cclr), .CE(cco0),
`ifdef UP_CNT_MOD_LOAD_EN
        .LD(ld_off), .D(d_off),
`endif
        .Q(cq1), .CO(cco1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    typedef struct {
        logic       clr;
        logic       ce;
        logic [3:0] exp_q;
        logic       exp_co;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic clr, input logic ce, input int q, input logic co);
        vec_t v;
        v.clr = clr; v.ce = ce; v.exp_q = 4'(q); v.exp_co = co;
        vecs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int m10, m16, cnt;
        logic r_clr, r_ce, r_ld;
        logic [3:0] r_d;
        logic r_clr16, r_ce16;

        // ---- vector table for MODULO=10 ----
        for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 0, 1'b0);   // clear with CE=1
        for (int i = 1; i <= 3; i++) add(1'b0, 1'b1, i, 1'b0);  // count up to 3
        for (int i = 0; i < 10; i++) add(1'b0, 1'b0, 3, 1'b0);  // hold at 3
        for (int i = 4; i <= 8; i++) add(1'b0, 1'b1, i, 1'b0);
        add(1'b0, 1'b1, 9, 1'b1);                               // terminal, enabled
        add(1'b0, 1'b0, 9, 1'b0);                               // held at 9, CO low
        add(1'b0, 1'b1, 0, 1'b0);                               // wrap
        for (int i = 1; i <= 5; i++) add(1'b0, 1'b1, i, 1'b0);
        add(1'b1, 1'b1, 0, 1'b0);                               // clear mid-count wins
        add(1'b1, 1'b0, 0, 1'b0);
        add(1'b0, 1'b1, 1, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            clr10 = vecs[i].clr;
            ce10  = vecs[i].ce;
            tick();
            chk($sformatf("vec%0d_q", i), 32'(q10), 32'(vecs[i].exp_q));
            chk($sformatf("vec%0d_co", i), 32'(co10), 32'(vecs[i].exp_co));
        end

        // ---- CO follows CE combinationally at Q=9 ----
        clr10 = 1'b0; ce10 = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("co_q9_q", 32'(q10), 32'd9);
        chk("co_q9_en", 32'(co10), 32'd1);
        ce10 = 1'b0; #1;
        chk("co_q9_drop", 32'(co10), 32'd0);
        ce10 = 1'b1; #1;
        chk("co_q9_rise", 32'(co10), 32'd1);
        tick();
        chk("co_wrap_q", 32'(q10), 32'd0);
        chk("co_wrap_co", 32'(co10), 32'd0);

        // ---- parallel load ----
        if (LOAD_EN) begin
            ce10 = 1'b0; ld10 = 1'b1; d10 = 4'd7; tick();
            chk("ld_7", 32'(q10), 32'd7);
            d10 = 4'd12; tick();
            chk("ld_12_clamp", 32'(q10), 32'd0);
            d10 = 4'd9; ce10 = 1'b1; tick();
            chk("ld_9_q", 32'(q10), 32'd9);
            chk("ld_9_co", 32'(co10), 32'd1);
            clr10 = 1'b1; d10 = 4'd5; tick();
            chk("clr_over_ld", 32'(q10), 32'd0);
            clr10 = 1'b0; ld10 = 1'b0; ce10 = 1'b0;
        end

        // ---- full-range modulus 16 ----
        clr16 = 1'b1; ce16 = 1'b1; tick();
        chk("m16_clr", 32'(q16), 32'd0);
        clr16 = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk($sformatf("m16_q_%0d", i), 32'(q16), 32'(i % 16));
            chk($sformatf("m16_co_%0d", i), 32'(co16), 32'((i % 16) == 15));
        end

        // ---- two-decade cascade 00..99, 00 ----
        cclr = 1'b1; cce0 = 1'b1; tick();
        chk("casc_clr", 32'({cq1, cq0}), 32'd0);
        cclr = 1'b0;
        for (int i = 1; i <= 101; i++) begin
            tick();
            cnt = i % 100;
            chk($sformatf("casc_q_%0d", i), 32'({cq1, cq0}), 32'({4'(cnt / 10), 4'(cnt % 10)}));
            chk($sformatf("casc_co1_%0d", i), 32'(cco1), 32'(cnt == 99));
        end
        cce0 = 1'b0;

        // ---- randomized run against arithmetic model ----
        clr10 = 1'b1; clr16 = 1'b1; ld10 = 1'b0; tick();
        m10 = 0; m16 = 0;
        for (int i = 0; i < 400; i++) begin
            r_clr   = ($urandom_range(0, 19) == 0);
            r_ce    = ($urandom_range(0, 3) != 0);
            r_ld    = LOAD_EN && ($urandom_range(0, 7) == 0);
            r_d     = 4'($urandom_range(0, 15));
            r_clr16 = ($urandom_range(0, 29) == 0);
            r_ce16  = $urandom_range(0, 1);
            clr10 = r_clr; ce10 = r_ce; ld10 = r_ld; d10 = r_d;
            clr16 = r_clr16; ce16 = r_ce16;
            #1;
            chk($sformatf("rnd%0d_co10", i), 32'(co10), 32'(r_ce && (m10 == 9)));
            chk($sformatf("rnd%0d_co16", i), 32'(co16), 32'(r_ce16 && (m16 == 15)));
            if (r_clr) m10 = 0;
            else if (r_ld) m10 = (int'(r_d) < 10) ? int'(r_d) : 0;
            else if (r_ce) m10 = (m10 + 1) % 10;
            if (r_clr16) m16 = 0;
            else if (r_ce16) m16 = (m16 + 1) % 16;
            tick();
            chk($sformatf("rnd%0d_q10", i), 32'(q10), 32'(m10));
            chk($sformatf("rnd%0d_q16", i), 32'(q16), 32'(m16));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/up_cnt_mod.md
Name: up_cnt_mod

Overview:
Synchronous up-counter that counts modulo MODULO and has a clock-enable and a combinational carry-out. Instances cascade by driving the next stage's CE from the previous stage's CO, for example two MODULO=10 decades forming a 00..99 BCD counter. It is a generic building block for timebases, dividers and decimal display counters.

Parameters:
- MODULO, 10, count modulus; Q sequences 0..MODULO-1. Legal range 2 <= MODULO <= 2**W.
- W, 4, width of Q in bits.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- CLR  input  1  synchronous active-high reset/clear.
- CE  input  1  count enable.
- Q  output  W  current count value (registered).
- CO  output  1  carry-out; combinational.

Behaviour:
- Reset is synchronous and active-high. On a rising CLK edge with CLR=1, Q <= 0 regardless of CE. CLR has highest priority.
- Reset value: Q = 0. CO is therefore 0 after reset whatever CE is, because Q != MODULO-1 (MODULO >= 2).
- Counting, on a rising edge with CLR=0 and CE=1:
  - If Q == MODULO-1, Q <= 0 (wrap).
  - Otherwise Q <= Q+1.
- Hold: on a rising edge with CLR=0 and CE=0, Q is unchanged.
- CO = CE & (Q == MODULO-1). It is purely combinational, with no register stage. It asserts in the same cycle as the terminal count when enabled, so a downstream stage clocked by the same CLK increments on exactly the edge where this stage wraps.
- Latency:
  - Q changes 1 cycle after a qualifying CE.
  - CO has zero latency from CE and Q.
- Arithmetic:
  - The comparison and increment use W-bit unsigned values.
  - When MODULO == 2**W, the wrap is explicit; natural overflow must not be relied on.
- Q never holds a value >= MODULO during normal operation.
- Simultaneous events:
  - CLR=1 with CE=1: clear wins, Q=0.
  - CLR asserted mid-count: Q returns to 0 on the next edge.
- Elaboration check: MODULO < 2 or MODULO > 2**W must cause an elaboration-time error ($error in a generate-if).

Optional Feature:
- Macro: UP_CNT_MOD_LOAD_EN.
- Defined: adds two ports, LD (input, 1) and D (input, W) for synchronous parallel load.
  - Priority is CLR > LD > CE.
  - With LD=1 and CLR=0, Q <= D if D < MODULO, else Q <= 0.
  - LD does not depend on CE.
  - CO keeps the same equation and is unaffected by LD.
- Undefined: the LD and D ports do not exist; behaviour is exactly as above.

Decomposition:
- No shared package is needed. A localparam TERM = MODULO-1 (W bits) lives in the module.
- No sub-module; a single flat module.
- The cascade (multi-digit counter) is composed at the instantiating level, not inside this block.

Test Plan:
- Reset with CE=1: hold CLR=1 for 3 edges -> Q=0 and CO=0 throughout. Release CLR -> Q=1 after the first edge.
- Hold: CLR=0, CE=0 for 10 edges at Q=3 -> Q stays 3, CO=0.
- Wrap, MODULO=10, W=4, CE=1 -> Q: 0,1,...,9,0. CO=1 only while Q=9, and it drops combinationally when CE falls at Q=9.
- Two-decade cascade: CE of stage1 = CO of stage0, CE0=1, for 100 edges from reset -> Q1:Q0 steps 00..99 then 00.
  - Q1 increments exactly on the edge where Q0 goes 9->0.
  - CO1 is 1 only at count 99.
- Full-range modulus, MODULO=16, W=4 -> Q: 0..15, 0. CO at 15. No X, no glitch values >= 16.
- With UP_CNT_MOD_LOAD_EN:
  - LD=1, D=7, CE=0 -> Q=7.
  - LD=1, D=12 (MODULO=10) -> Q=0.
  - CLR=1 and LD=1 together -> Q=0.
